irq_controller: RTL and testbench
=================================

# irq_controller

Interrupt front-end that sits directly upstream of the processor's `interrupt` input. It synchronises external request lines, latches rising edges as pending requests and applies a mask. It grants the highest-priority request and holds the `interrupt` line until the fetch/decode buffer captures it. It then blocks further requests until the processor signals that RTI has retired.

## Interface
Parameters:
- `N_SRC`, 4: number of external interrupt sources, 1..8.
- `W`, 16: data width of the vector output.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset is asynchronous and active-low.
- `irq_src`  in  N_SRC: asynchronous external request lines; a request is a rising edge.
- `mask_we`  in  1: mask register write strobe.
- `mask_wd`  in  N_SRC: mask write data; bit=1 masks that source.
- `fetch_ready`  in  1: processor F/D buffer enable; high means `interrupt` is captured this cycle.
- `rti_done`  in  1: one-cycle pulse when RTI retires in the processor.
- `interrupt`  out  1: request to the processor; registered.
- `vector`  out  W: zero-extended index of the granted source; registered.
- `pending`  out  N_SRC: pending register.
- `in_service`  out  1: high while the granted interrupt is being serviced.

## Operation
- Each `irq_src` bit passes through a 2-flop synchroniser, then a previous-value flop. `edge = sync2 & ~prev`.
- `pending[i]` is set on `edge[i]`. It is cleared when source i is accepted (ASSERT with `fetch_ready`=1).
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - Edges on an already-pending bit merge; there is no counting.
- `mask` is written on `mask_we`. Masked sources still latch pending but are not eligible. `eligible = pending & ~mask`.
- Priority is fixed: lowest index is highest.
- FSM states:
  - IDLE: if `eligible`≠0, latch `grant_idx` = highest-priority eligible index and go to ASSERT. Otherwise stay.
  - ASSERT: `interrupt`=1. If `fetch_ready`=1, clear `pending[grant_idx]` and go to SERVICE. Otherwise hold; `grant_idx` does not change, even if a higher-priority source arrives or the grant becomes masked.
  - SERVICE: `interrupt`=0, `in_service`=1. On `rti_done`, go to IDLE. There is no nesting.
- `rti_done` in IDLE or ASSERT is ignored.
- A mask write during ASSERT or SERVICE does not affect the current grant.
- `vector` = `grant_idx` zero-extended to W. It is loaded on IDLE→ASSERT and held until the next grant.

## Timing
- Reset (async assert, any state):
  - state = IDLE.
  - `interrupt`=0, `vector`=0, `pending`=0, `in_service`=0.
  - mask = 0.
  - All sync and prev flops = 0.
  - Reset mid-ASSERT or mid-SERVICE discards the grant.
- Reset deassertion is used synchronously.
- Latency: `irq_src[i]` rises before clock edge E1.
  - sync1 set at E1, sync2 set at E2.
  - `pending[i]` set at E3.
  - FSM enters ASSERT at E4; `interrupt`=1 after E4.
- With `fetch_ready` held high: `interrupt` is high for exactly 1 cycle, and `in_service`=1 from E5.
- `interrupt` and `in_service` are never high together.
- After `rti_done` at edge R, state is IDLE after R. A still-eligible request re-enters ASSERT at R+1, with `interrupt`=1 after R+1.
- The `pending` output reflects the register, so it updates the edge after the event.

## Structure
- Shared package:
  - FSM state encoding localparams (IDLE=2'b00, ASSERT=2'b01, SERVICE=2'b10).
  - Default `W`, matching the processor data width.
- Sub-module `irq_sync_edge`: 2-flop synchroniser, prev flop and rising-edge output for one bit. Instantiate it N_SRC times with a generate loop.
- Priority encoder and FSM live in `irq_controller`.

## Test plan
- Reset, then pulse `irq_src`=4'b0100 high; `fetch_ready`=1 → `pending`=4'b0100 after E3; `interrupt`=1 for one cycle after E4; `vector`=16'h0002; `pending`=0 and `in_service`=1 from E5.
- Raise sources 3 and 1 simultaneously; `rti_done` after the first grant → `vector`=1 first; after `rti_done`, `vector`=3 and `interrupt` is high again.
- `fetch_ready`=0 for 5 cycles during ASSERT, and source 0 edges in the meantime → `interrupt` is held high for all 5 cycles; `vector` stays unchanged; `pending[0]` sets; the grant is accepted when `fetch_ready` returns to 1.
- `mask`=4'b0001, edge on source 0 → `pending[0]`=1 with no `interrupt`. Write `mask`=0 → `interrupt` follows 1 cycle after the mask write takes effect, with `vector`=0.
- Assert `rst` low in SERVICE with `pending`=4'b1000 → all outputs are 0 immediately. After release there is no `interrupt` until a new edge.
- Edge on the granted source in the same cycle as acceptance → that pending bit remains 1.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt front-end: FSM state encoding and vector width.
// Latency: not applicable (types, constants and a helper function only).
// Backpressure: not applicable.
package irq_controller_pkg;

    // FSM encoding, kept stable so state values are recognisable in waveforms
    localparam logic [1:0] ST_IDLE_ENC    = 2'b00;
    localparam logic [1:0] ST_ASSERT_ENC  = 2'b01;
    localparam logic [1:0] ST_SERVICE_ENC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = ST_IDLE_ENC,
        ST_ASSERT  = ST_ASSERT_ENC,
        ST_SERVICE = ST_SERVICE_ENC
    } irq_state_t;

    // Vector width defaults to the processor data width
    localparam int IRQ_DATA_W = 16;

    // Width of a source index; a single source still needs one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request line: 2-flop synchroniser, history flop and rising-edge detect.
// Latency: an input rise is seen on rise two edges later, for exactly one cycle.
// Backpressure: none; the edge pulse is lost unless the consumer latches it.
module irq_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronise the asynchronous line, then keep one cycle of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt front-end: latches source edges as pending, masks, grants the lowest index.
// Latency: source rise to interrupt is 4 edges; interrupt drops the edge after fetch_ready.
// Backpressure: interrupt is held until fetch_ready; new grants wait for rti_done.
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int W     = IRQ_DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wd,
    input  logic             fetch_ready,
    input  logic             rti_done,
    output logic             interrupt,
    output logic [W-1:0]     vector,
    output logic [N_SRC-1:0] pending,
    output logic             in_service
);

    localparam int IDX_W = idx_width(N_SRC);

    irq_state_t       state;
    irq_state_t       state_nxt;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_vec;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] prio_idx;
    logic             accept;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        irq_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (irq_src[i]),
            .rise (rise[i])
        );
    end

    assign eligible = pending & ~mask;
    assign accept   = (state == ST_ASSERT) && fetch_ready;

    // Fixed priority: scan downwards so the lowest eligible index is the last write
    always_comb begin
        prio_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                prio_idx = IDX_W'(i);
            end
        end
    end

    // One-hot clear of the granted source in the cycle the processor captures it
    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[grant_idx] = 1'b1;
        end
    end

    // Next-state: grant, hold until captured, then block until RTI retires
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (|eligible)  state_nxt = ST_ASSERT;
            ST_ASSERT:  if (fetch_ready) state_nxt = ST_SERVICE;
            ST_SERVICE: if (rti_done)   state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // State register, grant latch and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            interrupt  <= 1'b0;
            in_service <= 1'b0;
        end else begin
            state      <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_ASSERT) begin
                grant_idx <= prio_idx;
            end
            interrupt  <= (state_nxt == ST_ASSERT);
            in_service <= (state_nxt == ST_SERVICE);
        end
    end

    // Pending and mask registers; a new edge wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | rise;
            if (mask_we) begin
                mask <= mask_wd;
            end
        end
    end

    assign vector = W'(grant_idx);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic.
// Latency: a reference model predicts outputs per edge; a monitor compares at negedge.
// Backpressure: fetch_ready and rti_done are driven by the bench, randomly or directed.
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_src;
    logic        mask_we;
    logic [3:0]  mask_wd;
    logic        fetch_ready;
    logic        rti_done;
    logic        interrupt;
    logic [15:0] vector;
    logic [3:0]  pending;
    logic        in_service;

    irq_controller #(.N_SRC(4), .W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_src     (irq_src),
        .mask_we     (mask_we),
        .mask_wd     (mask_wd),
        .fetch_ready (fetch_ready),
        .rti_done    (rti_done),
        .interrupt   (interrupt),
        .vector      (vector),
        .pending     (pending),
        .in_service  (in_service)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic        intr;
        logic        svc;
        logic [3:0]  pend;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   grant_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: sampled input history, pending set, mask, and the grant life-cycle
    logic [3:0] m_s1, m_s2, m_s3;
    logic [3:0] m_pend, m_mask;
    int         m_phase;   // 0 = no grant, 1 = offered to processor, 2 = being serviced
    int         m_owner;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_s1 = '0; m_s2 = '0; m_s3 = '0;
        m_pend = '0; m_mask = '0;
        m_phase = 0; m_owner = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were applied at that edge
    task automatic model_edge(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                              input logic fr, input logic rti);
        logic [3:0] rises;
        logic [3:0] taken;
        exp_t       e;
        rises = m_s2 & ~m_s3;   // a sample that rose two edges ago becomes pending now
        taken = '0;
        if (m_phase == 0) begin
            if ((m_pend & ~m_mask) != 0) begin
                m_owner = lowest(m_pend & ~m_mask);
                m_phase = 1;
                grant_q.push_back(m_owner);
            end
        end else if (m_phase == 1) begin
            if (fr) begin
                taken[m_owner] = 1'b1;
                m_phase = 2;
            end
        end else if (rti) begin
            m_phase = 0;
        end
        m_pend = (m_pend & ~taken) | rises;
        if (mwe) m_mask = mwd;
        m_s3 = m_s2; m_s2 = m_s1; m_s1 = irq;
        e.intr = (m_phase == 1);
        e.svc  = (m_phase == 2);
        e.pend = m_pend;
        e.vec  = 16'(m_owner);
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [3:0] irq, input logic mwe, input logic [3:0] mwd,
                        input logic fr, input logic rti);
        irq_src = irq; mask_we = mwe; mask_wd = mwd; fetch_ready = fr; rti_done = rti;
        @(posedge clk);
        #1;
        model_edge(irq, mwe, mwd, fr, rti);
    endtask

    task automatic run(input int n, input logic [3:0] irq, input logic fr, input logic rti);
        repeat (n) step(irq, 1'b0, 4'b0, fr, rti);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        irq_src = '0; mask_we = 1'b0; mask_wd = '0; fetch_ready = 1'b0; rti_done = 1'b0;
        #1;
        check("rst_interrupt", interrupt, 0);
        check("rst_vector", vector, 0);
        check("rst_pending", pending, 0);
        check("rst_in_service", in_service, 0);
        exp_q.delete();
        grant_q.delete();
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Monitor: pop the expected response for each edge, and match each new grant in order
    exp_t e_mon;
    int   g_mon;
    logic last_int = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            last_int = 1'b0;
        end else begin
            if (exp_q.size() > 0) begin
                e_mon = exp_q.pop_front();
                check("interrupt", interrupt, e_mon.intr);
                check("in_service", in_service, e_mon.svc);
                check("pending", pending, e_mon.pend);
                check("vector", vector, e_mon.vec);
            end
            if (interrupt === 1'b1 && last_int == 1'b0) begin
                if (grant_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_grant: interrupt rose with vector %0h, no grant expected", vector);
                end else begin
                    g_mon = grant_q.pop_front();
                    check("grant_vector", vector, g_mon);
                end
            end
            last_int = interrupt;
        end
    end

    logic [3:0] r_irq;

    initial begin
        rst = 1'b0;
        irq_src = '0; mask_we = 1'b0; mask_wd = '0; fetch_ready = 1'b0; rti_done = 1'b0;
        model_clear();
        do_reset();

        // Single source 2, processor always ready
        step(4'b0100, 1'b0, 4'b0, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0, 1'b1, 1'b0);
        step(4'b0100, 1'b0, 4'b0, 1'b1, 1'b0);
        check("e3_pending", pending, 4'b0100);
        check("e3_interrupt", interrupt, 0);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        check("e4_interrupt", interrupt, 1);
        check("e4_vector", vector, 16'h0002);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        check("e5_interrupt", interrupt, 0);
        check("e5_in_service", in_service, 1);
        check("e5_pending", pending, 0);
        run(12, 4'b0000, 1'b1, 1'b1);

        // Sources 3 and 1 together: 1 first, 3 after RTI
        step(4'b1010, 1'b0, 4'b0, 1'b1, 1'b0);
        run(3, 4'b0000, 1'b1, 1'b0);
        check("pair_first_vector", vector, 16'h0001);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        check("pair_second_interrupt", interrupt, 1);
        check("pair_second_vector", vector, 16'h0003);
        run(12, 4'b0000, 1'b1, 1'b1);

        // Processor stalls for 5 cycles while a higher-priority source arrives
        step(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        run(3, 4'b0000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            step((k == 0) ? 4'b0001 : 4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
            check("stall_interrupt", interrupt, 1);
            check("stall_vector", vector, 16'h0002);
        end
        check("stall_pending0", pending[0], 1);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        check("stall_accept", in_service, 1);
        run(12, 4'b0000, 1'b1, 1'b1);

        // Masked source latches pending but is not granted until unmasked
        step(4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0);
        step(4'b0001, 1'b0, 4'b0, 1'b1, 1'b0);
        run(5, 4'b0000, 1'b1, 1'b0);
        check("masked_pending", pending, 4'b0001);
        check("masked_interrupt", interrupt, 0);
        step(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        check("unmask_interrupt_early", interrupt, 0);
        step(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
        check("unmask_interrupt", interrupt, 1);
        check("unmask_vector", vector, 16'h0000);
        run(12, 4'b0000, 1'b1, 1'b1);

        // Reset in service with source 3 pending
        step(4'b0010, 1'b0, 4'b0, 1'b1, 1'b0);
        run(4, 4'b1010, 1'b1, 1'b0);
        check("pre_rst_in_service", in_service, 1);
        check("pre_rst_pending", pending, 4'b1000);
        do_reset();
        run(8, 4'b0000, 1'b1, 1'b0);
        check("post_rst_pending", pending, 0);
        check("post_rst_interrupt", interrupt, 0);

        // Granted source edges again in the acceptance cycle: set wins
        step(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        run(3, 4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 4'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 4'b0, 1'b1, 1'b0);
        check("setwins_pending2", pending[2], 1);
        check("setwins_in_service", in_service, 1);
        run(12, 4'b0000, 1'b1, 1'b1);

        // Random traffic
        r_irq = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) r_irq = 4'($urandom_range(0, 15));
            step(r_irq, ($urandom_range(0, 15) == 0),
                 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
        end
        step(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1);
        run(20, 4'b0000, 1'b1, 1'b1);

        @(negedge clk);
        #1;
        check("grants_left", grant_q.size(), 0);
        check("expects_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
